// File: rtl/router_pkg.sv
// Shared definitions for the packet TX scheduler and router slice:
// scheduler states, field widths and traffic-source IDs.
package router_pkg;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned SIZE_W = 3;

  localparam logic [ID_W-1:0] TS1 = 8'd5;
  localparam logic [ID_W-1:0] TS2 = 8'd6;
  localparam logic [ID_W-1:0] TS3 = 8'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2,
    StGap  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr+1 (mod NUM_REQ)
// and returns the first active request as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr) + k) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_scheduler.sv
// Round-robin scheduler sharing one packet transmitter between NUM_REQ sources,
// with size-0 drop, FIFO-full backpressure and a fixed inter-packet gap.
module pkt_tx_scheduler
  import router_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ID_W*NUM_REQ-1:0]   req_srcid,
  input  logic [ID_W*NUM_REQ-1:0]   req_dstid,
  input  logic [SIZE_W*NUM_REQ-1:0] req_size,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      tx_start,
  output logic [ID_W-1:0]           tx_srcid,
  output logic [ID_W-1:0]           tx_dstid,
  output logic [SIZE_W-1:0]         tx_size,
  output logic                      tx_stop,
  input  logic                      tx_sop,
  input  logic                      tx_eop,
  output logic                      busy,
  output logic                      err_drop,
  output logic [CNT_W-1:0]          pkt_count
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e state_q, state_d;

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic [ID_W-1:0]    tx_srcid_q, tx_srcid_d;
  logic [ID_W-1:0]    tx_dstid_q, tx_dstid_d;
  logic [SIZE_W-1:0]  tx_size_q, tx_size_d;
  logic               tx_stop_q, tx_stop_d;
  logic               busy_q, busy_d;
  logic               err_drop_q, err_drop_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

  logic               arb_en;
  logic               arb_valid;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic [ID_W-1:0]    sel_srcid;
  logic [ID_W-1:0]    sel_dstid;
  logic [SIZE_W-1:0]  sel_size;
  logic               pkt_done;

  assign arb_en = (state_q == StIdle) && !fifo_full;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req(req),
    .ptr(ptr_q),
    .en (arb_en),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign arb_valid = |arb_gnt;
  assign sel_srcid = req_srcid[arb_idx*ID_W +: ID_W];
  assign sel_dstid = req_dstid[arb_idx*ID_W +: ID_W];
  assign sel_size  = req_size[arb_idx*SIZE_W +: SIZE_W];

  // sop+eop together in LOAD is a complete packet as well.
  assign pkt_done = ((state_q == StLoad) && tx_sop && tx_eop) ||
                    ((state_q == StSend) && tx_eop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NUM_REQ - 1);
      gnt_idx_q   <= '0;
      gap_cnt_q   <= '0;
      grant_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_srcid_q  <= '0;
      tx_dstid_q  <= '0;
      tx_size_q   <= '0;
      tx_stop_q   <= 1'b1;
      busy_q      <= 1'b0;
      err_drop_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      grant_q     <= grant_d;
      tx_start_q  <= tx_start_d;
      tx_srcid_q  <= tx_srcid_d;
      tx_dstid_q  <= tx_dstid_d;
      tx_size_q   <= tx_size_d;
      tx_stop_q   <= tx_stop_d;
      busy_q      <= busy_d;
      err_drop_q  <= err_drop_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid && (sel_size != '0)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (tx_sop) begin
          if (tx_eop) begin
            state_d   = StGap;
            gap_cnt_d = GapW'(GAP_CYCLES - 1);
          end else begin
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (tx_eop) begin
          state_d   = StGap;
          gap_cnt_d = GapW'(GAP_CYCLES - 1);
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d     = '0;
    err_drop_d  = 1'b0;
    tx_srcid_d  = tx_srcid_q;
    tx_dstid_d  = tx_dstid_q;
    tx_size_d   = tx_size_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    pkt_count_d = pkt_count_q;
    if (arb_valid) begin
      grant_d    = arb_gnt;
      tx_srcid_d = sel_srcid;
      tx_dstid_d = sel_dstid;
      tx_size_d  = sel_size;
      gnt_idx_d  = arb_idx;
      if (sel_size == '0) begin
        err_drop_d = 1'b1;
        ptr_d      = arb_idx;
      end
    end
    if (pkt_done) begin
      pkt_count_d = pkt_count_q + CNT_W'(1);
      ptr_d       = gnt_idx_q;
    end
    // Start is raised one cycle after the grant and dropped on the eop edge.
    tx_start_d = ((state_q == StLoad) || (state_q == StSend)) && (state_d != StGap);
    tx_stop_d  = (state_d == StGap);
    busy_d     = (state_d != StIdle);
  end

  assign grant     = grant_q;
  assign tx_start  = tx_start_q;
  assign tx_srcid  = tx_srcid_q;
  assign tx_dstid  = tx_dstid_q;
  assign tx_size   = tx_size_q;
  assign tx_stop   = tx_stop_q;
  assign busy      = busy_q;
  assign err_drop  = err_drop_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// Directed bench for pkt_tx_scheduler: a scoreboard of expected grants/fields
// checked as each grant appears, with a simple transmitter model in the flow.
module tb_pkt_tx_scheduler;
  import router_pkg::*;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned GAP_CYCLES = 3;
  localparam int unsigned CNT_W      = 8;

  logic                      wr_clk_tb;
  logic                      rst_tb;
  logic [NUM_REQ-1:0]        req;
  logic [ID_W*NUM_REQ-1:0]   req_srcid;
  logic [ID_W*NUM_REQ-1:0]   req_dstid;
  logic [SIZE_W*NUM_REQ-1:0] req_size;
  logic [NUM_REQ-1:0]        grant;
  logic                      fifo_full;
  logic                      tx_start;
  logic [ID_W-1:0]           tx_srcid;
  logic [ID_W-1:0]           tx_dstid;
  logic [SIZE_W-1:0]         tx_size;
  logic                      tx_stop;
  logic                      tx_sop;
  logic                      tx_eop;
  logic                      busy;
  logic                      err_drop;
  logic [CNT_W-1:0]          pkt_count;

  typedef struct {
    logic [2:0] gnt;
    logic [7:0] src;
    logic [7:0] dst;
    logic [2:0] sz;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   drop_cnt = 0;
  int   lat;

  pkt_tx_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (wr_clk_tb),
    .rst      (rst_tb),
    .req      (req),
    .req_srcid(req_srcid),
    .req_dstid(req_dstid),
    .req_size (req_size),
    .grant    (grant),
    .fifo_full(fifo_full),
    .tx_start (tx_start),
    .tx_srcid (tx_srcid),
    .tx_dstid (tx_dstid),
    .tx_size  (tx_size),
    .tx_stop  (tx_stop),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop),
    .busy     (busy),
    .err_drop (err_drop),
    .pkt_count(pkt_count)
  );

  initial wr_clk_tb = 1'b0;
  always #5 wr_clk_tb = ~wr_clk_tb;

  always @(posedge wr_clk_tb) begin
    #1;
    if (err_drop === 1'b1) drop_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge wr_clk_tb);
    #1;
  endtask

  task automatic idle_wait();
    repeat (GAP_CYCLES + 1) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_src(input int i, input logic [7:0] s, input logic [7:0] d,
                         input logic [2:0] z);
    req_srcid[i*8 +: 8] = s;
    req_dstid[i*8 +: 8] = d;
    req_size[i*3 +: 3]  = z;
  endtask

  task automatic expect_pkt(input logic [2:0] g, input logic [7:0] s, input logic [7:0] d,
                            input logic [2:0] z);
    sb.push_back('{gnt: g, src: s, dst: d, sz: z});
  endtask

  // Wait for a grant, check it against the scoreboard, then play transmitter.
  task automatic serve(input bit keep_req, input bit mid_full, input bit same,
                       output int lat_o);
    exp_t e;
    lat_o = 0;
    do begin
      tick();
      lat_o++;
    end while (grant === '0 && lat_o < 40);
    chk("grant_seen", 32'(grant !== '0), 1);
    if (grant === '0) return;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("grant", grant, e.gnt);
    chk("tx_srcid", tx_srcid, e.src);
    chk("tx_dstid", tx_dstid, e.dst);
    chk("tx_size", tx_size, e.sz);
    chk("start_lag", tx_start, 0);
    if (!keep_req) req = req & ~grant;
    tick();
    chk("tx_start", tx_start, 1);
    chk("busy", busy, 1);
    tx_sop = 1'b1;
    if (same) tx_eop = 1'b1;
    if (mid_full) fifo_full = 1'b1;
    tick();
    tx_sop = 1'b0;
    tx_eop = 1'b0;
    if (!same) begin
      tick();
      chk("start_hold", tx_start, 1);
      chk("size_hold", tx_size, e.sz);
      tx_eop = 1'b1;
      tick();
      tx_eop = 1'b0;
    end
    fifo_full = 1'b0;
    chk("start_drop", tx_start, 0);
    chk("stop_gap", tx_stop, 1);
  endtask

  initial begin
    rst_tb    = 1'b1;
    req       = '0;
    req_srcid = '0;
    req_dstid = '0;
    req_size  = '0;
    fifo_full = 1'b0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_stop", tx_stop, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", pkt_count, 0);
    chk("rst_drop", err_drop, 0);
    chk("rst_srcid", tx_srcid, 0);
    chk("rst_size", tx_size, 0);
    rst_tb = 1'b0;
    tick();
    chk("idle_stop", tx_stop, 0);

    // Single request from source 0.
    set_src(0, TS1, 8'hF8, 3'd4);
    expect_pkt(3'b001, TS1, 8'hF8, 3'd4);
    req = 3'b001;
    serve(1'b0, 1'b0, 1'b0, lat);
    chk("single_lat", lat, 1);
    tick();
    chk("gap2", tx_stop, 1);
    tick();
    chk("gap3", tx_stop, 1);
    tick();
    chk("gap_end", tx_stop, 0);
    chk("single_count", pkt_count, 1);

    // All three requesting continuously, from a fresh reset.
    rst_tb = 1'b1;
    tick();
    rst_tb = 1'b0;
    tick();
    set_src(0, TS1, 8'h10, 3'd4);
    set_src(1, TS2, 8'h20, 3'd4);
    set_src(2, TS3, 8'h30, 3'd4);
    for (int r = 0; r < 2; r++) begin
      expect_pkt(3'b001, TS1, 8'h10, 3'd4);
      expect_pkt(3'b010, TS2, 8'h20, 3'd4);
      expect_pkt(3'b100, TS3, 8'h30, 3'd4);
    end
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      serve(1'b1, 1'b0, 1'b0, lat);
      chk("rr_lat", lat, (i == 0) ? 1 : GAP_CYCLES + 1);
    end
    req = '0;
    chk("rr_count", pkt_count, 6);

    // Backpressure in IDLE, then fifo_full raised mid-packet.
    idle_wait();
    set_src(1, TS2, 8'h21, 3'd4);
    fifo_full = 1'b1;
    req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("full_nogrant", grant, 0);
    end
    expect_pkt(3'b010, TS2, 8'h21, 3'd4);
    fifo_full = 1'b0;
    serve(1'b0, 1'b1, 1'b0, lat);
    chk("full_lat", lat, 1);
    chk("full_count", pkt_count, 7);

    // Size-0 drop from source 0, then source 1.
    idle_wait();
    set_src(0, TS1, 8'h11, 3'd0);
    set_src(1, TS2, 8'h45, 3'd7);
    expect_pkt(3'b001, TS1, 8'h11, 3'd0);
    expect_pkt(3'b010, TS2, 8'h45, 3'd7);
    req = 3'b011;
    tick();
    begin
      exp_t e;
      e = sb.pop_front();
      chk("drop_grant", grant, e.gnt);
      chk("drop_size", tx_size, e.sz);
    end
    chk("drop_pulse", err_drop, 1);
    chk("drop_nostart", tx_start, 0);
    req[0] = 1'b0;
    serve(1'b0, 1'b0, 1'b0, lat);
    chk("after_drop_lat", lat, 1);
    chk("drop_once", drop_cnt, 1);
    chk("drop_count", pkt_count, 8);

    // Reset during SEND.
    idle_wait();
    set_src(1, TS2, 8'h22, 3'd5);
    req = 3'b010;
    tick();
    chk("mr_grant", grant, 3'b010);
    req = '0;
    tick();
    chk("mr_start", tx_start, 1);
    tx_sop = 1'b1;
    tick();
    tx_sop = 1'b0;
    rst_tb = 1'b1;
    tick();
    chk("mr_start_off", tx_start, 0);
    chk("mr_count", pkt_count, 0);
    chk("mr_busy", busy, 0);
    chk("mr_stop", tx_stop, 1);
    rst_tb = 1'b0;
    tick();
    set_src(0, TS1, 8'h12, 3'd2);
    set_src(2, TS3, 8'h32, 3'd2);
    expect_pkt(3'b001, TS1, 8'h12, 3'd2);
    req = 3'b111;
    serve(1'b0, 1'b0, 1'b0, lat);
    req = '0;
    chk("mr_prio_lat", lat, 1);
    chk("mr_recount", pkt_count, 1);

    // Counter wrap: 254 more to reach 255, then a sop+eop packet wraps to 0.
    set_src(0, TS1, 8'hA0, 3'd1);
    for (int i = 0; i < 254; i++) begin
      idle_wait();
      expect_pkt(3'b001, TS1, 8'hA0, 3'd1);
      req = 3'b001;
      serve(1'b0, 1'b0, 1'b0, lat);
    end
    chk("cnt_255", pkt_count, 255);
    idle_wait();
    expect_pkt(3'b001, TS1, 8'hA0, 3'd1);
    req = 3'b001;
    serve(1'b0, 1'b0, 1'b1, lat);
    chk("cnt_wrap", pkt_count, 0);
    idle_wait();
    tx_sop = 1'b1;
    tx_eop = 1'b1;
    tick();
    tx_sop = 1'b0;
    tx_eop = 1'b0;
    tick();
    chk("spur_count", pkt_count, 0);
    chk("spur_busy", busy, 0);
    chk("spur_start", tx_start, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_tx_scheduler.md
Name: pkt_tx_scheduler

Overview:
- Shares the single packet transmitter between NUM_REQ traffic sources (TS1..TS3) using round-robin arbitration.
- For each granted request it captures srcid, dstid and size, drives the transmitter's start/srcid/dstid/size/stop inputs, and tracks sop/eop until the packet completes.
- Enforces an inter-packet gap and blocks new grants while the router input FIFO is full.
- Sits between the traffic sources and the transmitter, upstream of the 1x3 router.

Parameters:
- NUM_REQ, 3, number of requesters.
- GAP_CYCLES, 3, cycles tx_stop is held high after each eop (minimum 1).
- CNT_W, 8, width of the completed-packet counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-source request; level, held until that source's grant bit pulses.
- req_srcid  in  8*NUM_REQ  flattened source IDs; requester i occupies bits [8i+7:8i].
- req_dstid  in  8*NUM_REQ  flattened destination IDs; requester i occupies bits [8i+7:8i].
- req_size  in  3*NUM_REQ  flattened payload byte counts; requester i occupies bits [3i+2:3i].
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- fifo_full  in  1  router input FIFO full (backpressure).
- tx_start  out  1  drives transmitter start_packet_gen.
- tx_srcid  out  8  drives transmitter srcid.
- tx_dstid  out  8  drives transmitter dstid.
- tx_size  out  3  drives transmitter actual_size.
- tx_stop  out  1  drives transmitter stop_packet.
- tx_sop  in  1  transmitter packet_starting.
- tx_eop  in  1  transmitter packet_ending.
- busy  out  1  high in every state except IDLE.
- err_drop  out  1  one-cycle pulse when a size-0 request is discarded.
- pkt_count  out  CNT_W  number of completed packets.

Behaviour:
- Reset (synchronous, rst=1 at the clk edge):
  - State goes to IDLE.
  - grant=0, tx_start=0, tx_srcid=0, tx_dstid=0, tx_size=0, busy=0, err_drop=0, pkt_count=0.
  - tx_stop=1 during reset.
  - Round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
- A reset asserted in any state aborts the packet: tx_start drops on the next edge and no count is taken.
- All outputs are registered.
- State machine has four states: IDLE, LOAD, SEND, GAP.
- IDLE:
  - tx_stop=0, tx_start=0.
  - Waits for (|req) && !fifo_full.
  - Selects the first requester with req set, scanning upward from ptr+1 modulo NUM_REQ.
  - On the selection edge: grant[i]=1 for one cycle, and req_srcid/req_dstid/req_size of requester i are latched into tx_srcid/tx_dstid/tx_size.
  - If the latched size is 0: err_drop pulses, ptr=i, and the state stays IDLE. No transmission occurs.
  - Otherwise the next state is LOAD.
  - If fifo_full is high, no grant is issued regardless of req.
- LOAD:
  - tx_start=1; tx_srcid, tx_dstid and tx_size are held stable.
  - On tx_sop the state goes to SEND.
  - If tx_sop and tx_eop arrive in the same cycle, the state goes directly to GAP and the packet is counted.
- SEND:
  - tx_start stays 1 and fields are held stable.
  - fifo_full is ignored mid-packet; a packet is never split.
  - On tx_eop: tx_start=0, pkt_count increments (wraps at 2^CNT_W-1 to 0), ptr=granted index, next state GAP.
- GAP:
  - tx_stop=1 and tx_start=0 for exactly GAP_CYCLES cycles, counted by an internal counter, then the state goes to IDLE.
  - Requests arriving during GAP are held by the source and arbitrated in IDLE.
- tx_sop or tx_eop seen in IDLE or GAP is ignored: no count and no state change.
- Latency:
  - The earliest grant is 1 cycle after req rises while in IDLE.
  - tx_start rises on the cycle after the grant.
  - Back-to-back packets: eop → next tx_start takes at least GAP_CYCLES+2 cycles.
- Fairness: a requester that keeps req high receives a grant within NUM_REQ arbitration rounds.
- A source deasserting req before its grant loses its request; there is no internal queuing.

Decomposition:
- Shared package router_pkg holds:
  - State encoding for IDLE/LOAD/SEND/GAP.
  - ID_W=8 and SIZE_W=3 constants.
  - Traffic-source IDs TS1=5, TS2=6, TS3=7.
- One sub-module, rr_arbiter (parameter NUM_REQ), covers request vector, pointer and enable in, and one-hot grant and index out, purely combinational.
- Everything else stays in the top-level pkt_tx_scheduler.

Test Plan:
- Reset then a single request:
  - Stimulus: req=3'b001, srcid=5, dstid=8'hF8, size=4.
  - grant=001 is 1 cycle after req.
  - tx_start=1 with tx_srcid=5, tx_dstid=F8 and tx_size=4 from the next cycle.
  - After tx_eop: tx_stop=1 for exactly 3 cycles, then pkt_count=1.
- All three requesting continuously:
  - Stimulus: req=3'b111, each source sized 4, 6 packets total.
  - Grants arrive in order 001, 010, 100, 001, 010, 100; pkt_count=6.
- fifo_full backpressure:
  - Stimulus: fifo_full=1 in IDLE with req=010 for 10 cycles.
  - No grant is issued while fifo_full=1.
  - Deassert fifo_full, then grant=010 the next cycle.
  - fifo_full raised during SEND has no effect and the packet completes.
- Size-0 drop:
  - Stimulus: req=001 with size=0, and req=010 with srcid=6, dstid=8'h45, size=7.
  - err_drop pulses once and no tx_start is issued for requester 0.
  - Next grant=010 with tx_size=7.
- Mid-packet reset:
  - Stimulus: rst=1 during SEND.
  - Next edge: tx_start=0, pkt_count=0, busy=0, tx_stop=1.
  - After rst release, requester 0 has priority again.
- Counter wrap:
  - Stimulus: preset via 256 packets with CNT_W=8.
  - pkt_count goes 255 → 0; spurious tx_eop in IDLE leaves it unchanged.
